store_drain_ctrl: RTL

- Buffers committed stores (sd/sw/sh/sb) from the writeback stage in an in-order queue.
- Issues the stores one at a time to the memory write port using a req/ack handshake.
- Provides a drain handshake: scall and end-of-program (ret) processing holds until every earlier store is visible in memory.
- Sits between writeback and the data-memory write port. It replaces direct pending-write calls made from writeback.

---
 rtl/store_drain_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/store_drain_ctrl.sv
// In-order store queue between writeback and the data-memory write port.
// Issues one store at a time over req/ack and reports when a requested drain has completed.
//   state | meaning
//   IDLE  | nothing presented to memory; leaves when the queue holds an entry
//   ISSUE | head store presented on the bus, held until acked
module store_drain_ctrl #(
    parameter int ADDRESS_WIDTH  = 64,
    parameter int REGISTER_WIDTH = 64,
    parameter int DEPTH          = 4,
    parameter int PTR_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_enable,
    input  logic [ADDRESS_WIDTH-1:0]  in_phy_addr,
    input  logic [REGISTER_WIDTH-1:0] in_rs2_value,
    input  logic [3:0]                in_size,
    input  logic                      in_drain_req,
    input  logic                      in_bus_ack,
    output logic                      out_full,
    output logic                      out_bad_size,
    output logic                      out_drain_done,
    output logic                      out_bus_req,
    output logic [ADDRESS_WIDTH-1:0]  out_bus_addr,
    output logic [REGISTER_WIDTH-1:0] out_bus_data,
    output logic [3:0]                out_bus_size,
    output logic [PTR_WIDTH:0]        out_count
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [PTR_WIDTH:0] COUNT_FULL = (PTR_WIDTH+1)'(DEPTH);

    state_t                    state;
    logic [ADDRESS_WIDTH-1:0]  mem_addr [DEPTH];
    logic [REGISTER_WIDTH-1:0] mem_data [DEPTH];
    logic [3:0]                mem_size [DEPTH];
    logic [PTR_WIDTH-1:0]      rd_ptr;
    logic [PTR_WIDTH-1:0]      wr_ptr;
    logic [PTR_WIDTH-1:0]      next_rd;
    logic [PTR_WIDTH:0]        count;
    logic [PTR_WIDTH:0]        count_next;
    logic                      size_ok;
    logic                      push;
    logic                      pop;
    logic [REGISTER_WIDTH-1:0] push_data;

    assign size_ok    = (in_size == 4'd1) || (in_size == 4'd2) ||
                        (in_size == 4'd4) || (in_size == 4'd8);
    assign out_full   = !reset && ((count == COUNT_FULL) || in_drain_req);
    assign push       = in_enable && !out_full && size_ok;
    assign pop        = (state == ISSUE) && in_bus_ack;
    assign count_next = count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    assign next_rd    = rd_ptr + PTR_WIDTH'(1);
    assign out_count  = count;

    always_comb begin
        push_data = '0;
        case (in_size)
            4'd1:    push_data[7:0]  = in_rs2_value[7:0];
            4'd2:    push_data[15:0] = in_rs2_value[15:0];
            4'd4:    push_data[31:0] = in_rs2_value[31:0];
            4'd8:    push_data       = in_rs2_value;
            default: push_data       = '0;
        endcase
    end

    // Storage needs no reset: occupancy is tracked entirely by count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= in_phy_addr;
            mem_data[wr_ptr] <= push_data;
            mem_size[wr_ptr] <= in_size;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            out_bad_size   <= 1'b0;
            out_drain_done <= 1'b0;
            out_bus_req    <= 1'b0;
            out_bus_addr   <= '0;
            out_bus_data   <= '0;
            out_bus_size   <= '0;
        end else begin
            count          <= count_next;
            out_bad_size   <= in_enable && !out_full && !size_ok;
            out_drain_done <= in_drain_req && (count == '0) && (state == IDLE);
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= next_rd;
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state        <= ISSUE;
                        out_bus_req  <= 1'b1;
                        out_bus_addr <= mem_addr[rd_ptr];
                        out_bus_data <= mem_data[rd_ptr];
                        out_bus_size <= mem_size[rd_ptr];
                    end
                end
                ISSUE: begin
                    if (in_bus_ack) begin
                        if (count_next == '0) begin
                            state       <= IDLE;
                            out_bus_req <= 1'b0;
                        end else if (count == (PTR_WIDTH+1)'(1)) begin
                            // Last entry leaving while a new one arrives: take it straight from the inputs.
                            out_bus_addr <= in_phy_addr;
                            out_bus_data <= push_data;
                            out_bus_size <= in_size;
                        end else begin
                            out_bus_addr <= mem_addr[next_rd];
                            out_bus_data <= mem_data[next_rd];
                            out_bus_size <= mem_size[next_rd];
                        end
                    end
                end
            endcase
        end
    end

endmodule
